uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Sequences CPU byte stores to the UART transmit-data address into the UART transmitter.
//  Sits between the data-memory write path and uart_top's transmitter.
//  Buffers bytes in a FIFO and issues them one at a time using a start/busy handshake.
//  Replaces the hang_uart stall with a stall that asserts only while the FIFO is full.
// PARAMETERS
//  DEPTH      8      FIFO entries; power of two, 2..64
//  DATA_W     8      byte width sent to transmitter
//  UDRT_ADDR  32'h3  word address that is decoded as a TX-data store
//  ACK_TMO    1023   cycles to wait for tx_busy rise before the byte is abandoned
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous reset, active-low
//  cpu_we     in   1       store strobe (MemWrite)
//  cpu_addr   in   32      store address (ALU result)
//  cpu_wdata  in   DATA_W  store data, low byte of rd2
//  flush      in   1       sync clear of FIFO; does not abort the byte already issued
//  cpu_stall  out  1       hold PC/instruction; = cpu_we & (cpu_addr==UDRT_ADDR) & full
//  tx_start   out  1       one-cycle pulse; transmitter latches tx_data
//  tx_data    out  DATA_W  byte to send, stable from tx_start until tx_busy falls
//  tx_busy    in   1       transmitter busy (USR[0])
//  level      out  clog2(DEPTH)+1  FIFO occupancy
//  ack_err    out  1       sticky; set on ack timeout, cleared only by reset
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty; level=0; state IDLE; tx_start=0; tx_data=0; ack_err=0.
//  cpu_stall is combinational and is 0 during reset.
//  Push: on a clk edge with cpu_we & addr hit & !full, cpu_wdata enters the tail. Otherwise nothing is written.
//  No same-cycle bypass: when full, the store stalls even if a pop occurs in that cycle.
//  The stalled store is retried on the next cycle because the CPU holds its instruction.
//  FSM states:
//   IDLE:      if !empty & !tx_busy -> LOAD.
//   LOAD:      pop the head into the tx_data register; tx_start=1 for exactly this cycle -> WAIT_ACK.
//   WAIT_ACK:  if tx_busy -> WAIT_DONE; if the counter reaches ACK_TMO -> set ack_err -> IDLE.
//   WAIT_DONE: if !tx_busy -> IDLE.
//  Minimum spacing between consecutive tx_start pulses is 3 cycles plus the transmitter busy time.
//  Latency: a byte pushed into an empty FIFO with an idle transmitter gives tx_start 2 cycles after the push edge.
//  Simultaneous push and pop: both happen; level is unchanged; pointers wrap modulo DEPTH.
//  Full: level==DEPTH. Empty: level==0. Pointers carry one extra bit to tell full from empty.
//  flush: pointers and level go to 0 on the next edge and a same-cycle push is discarded.
//   The FSM finishes its current WAIT_* state; a flush in LOAD still sends the byte already popped.
//  Reset mid-operation: all state is cleared immediately and tx_start drops asynchronously.
//   The transmitter is reset by the same rst.
//  tx_busy already high in IDLE (transmitter busy for another reason): stay in IDLE, no pulse.
//  Stores to other addresses are ignored; other writes in the same cycle never interact with this block.
// TESTING
//  1 Reset: rst=0 mid-WAIT_DONE with level=3 -> level=0, tx_start=0, state IDLE; 0 pulses after release.
//  2 Single byte: store 8'hA5 to UDRT_ADDR while idle, transmitter model raises busy 1 cycle after start, 10 cycles long
//    -> tx_start 2 cycles after the push edge, tx_data=8'hA5, level 1->0.
//  3 Fill: 9 back-to-back stores 8'h00..8'h08 with busy held high -> after 8 pushes level=8 and cpu_stall=1.
//    On release, 8'h08 is pushed on the first free cycle and bytes go out in order 00..08.
//  4 Simultaneous push/pop at level=4 -> level stays 4; order preserved across pointer wrap (>2*DEPTH bytes).
//  5 Timeout: transmitter model never raises busy -> after ACK_TMO cycles ack_err=1, next byte still issued.
//  6 Flush in LOAD with level=5 -> the popped byte is still transmitted; level=0 next cycle; no further tx_start.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - FIFO-buffered scheduler feeding CPU TX-data stores into the UART transmitter
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   cpu_we     store strobe from the data-memory write path
//   cpu_addr   store word address
//   cpu_wdata  store data (low byte)
//   flush      synchronous clear of the FIFO; the byte already issued is not aborted
//   cpu_stall  holds the CPU while a TX-data store finds the FIFO full
//   tx_start   one-cycle pulse; transmitter latches tx_data
//   tx_data    byte to send, held until the next issue
//   tx_busy    transmitter busy flag
//   level      FIFO occupancy
//   ack_err    sticky flag, set when the transmitter never acknowledged a start

module uart_tx_scheduler #(
    parameter int          DEPTH     = 8,
    parameter int          DATA_W    = 8,
    parameter logic [31:0] UDRT_ADDR = 32'h3,
    parameter int          ACK_TMO   = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_we,
    input  logic [31:0]                cpu_addr,
    input  logic [DATA_W-1:0]          cpu_wdata,
    input  logic                       flush,
    output logic                       cpu_stall,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ack_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(ACK_TMO + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic [CW-1:0]       tmo_cnt;
    logic                addr_hit;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;

    assign addr_hit  = (cpu_addr == UDRT_ADDR);
    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    // No bypass: a full FIFO stalls the store even on a cycle that pops.
    assign cpu_stall = cpu_we & addr_hit & full;
    assign push      = cpu_we & addr_hit & ~full & ~flush;
    // The empty guard covers a flush landing on the IDLE->LOAD edge.
    assign pop       = (state == S_LOAD) & ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // tx_start is registered: it rises on the edge that leaves LOAD, so the
    // byte and the pulse appear together one cycle after the LOAD decision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            ack_err  <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty && !tx_busy) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!empty) begin
                        tx_data  <= mem[rd_ptr[AW-1:0]];
                        tx_start <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= S_WAIT_ACK;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (tmo_cnt == CW'(ACK_TMO - 1)) begin
                        // Abandon the byte after ACK_TMO cycles without a busy rise.
                        ack_err <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler

module tb_uart_tx_scheduler;

    localparam int DEPTH   = 8;
    localparam int ACK_TMO = 1023;

    logic        clk;
    logic        rst;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        flush;
    logic        cpu_stall;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [3:0]  level;
    logic        ack_err;

    int vectors;
    int miscompares;

    // transmitter model: busy rises one cycle after tx_start, lasts 10 cycles
    logic       model_en;
    logic       force_busy;
    logic [3:0] bcnt;

    // record of every issued byte
    logic [7:0] sent [256];
    int         sent_n;

    uart_tx_scheduler #(
        .DEPTH(DEPTH), .DATA_W(8), .UDRT_ADDR(32'h3), .ACK_TMO(ACK_TMO)
    ) dut (
        .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .flush(flush), .cpu_stall(cpu_stall),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .level(level), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) bcnt <= 4'd0;
        else if (model_en && tx_start) bcnt <= 4'd10;
        else if (bcnt != 4'd0) bcnt <= bcnt - 4'd1;
    end

    assign tx_busy = force_busy | (bcnt != 4'd0);

    initial sent_n = 0;
    always @(posedge clk) begin
        if (tx_start && sent_n < 256) begin
            sent[sent_n] <= tx_data;
            sent_n       <= sent_n + 1;
        end
    end

    task automatic drive_store(input logic [7:0] b);
        cpu_we = 1'b1; cpu_addr = 32'h3; cpu_wdata = b;
    endtask

    task automatic idle_bus;
        cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 8'h00;
    endtask

    task automatic do_reset;
        @(negedge clk);
        idle_bus; flush = 1'b0; force_busy = 1'b0; model_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_sent(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (sent_n < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sent_n < target) begin
            miscompares++;
            $display("FAIL %s timeout: sent %0d want %0d", name, sent_n, target);
        end
    endtask

    task automatic test_reset;
        int snap;
        // reset state, with a TX store presented during reset
        drive_store(8'h11);
        #1;
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL rst_level got %0d want 0", level); end
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL rst_tx_start got %b want 0", tx_start); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
        vectors++; if (ack_err !== 1'b0) begin miscompares++; $display("FAIL rst_ack_err got %b want 0", ack_err); end
        vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %b want 0", cpu_stall); end
        do_reset;
        // four back-to-back stores: first goes out, three remain in WAIT_DONE
        for (int i = 0; i < 4; i++) begin
            drive_store(8'h20 + 8'(i));
            @(negedge clk);
        end
        idle_bus;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (level !== 4'd3) begin miscompares++; $display("FAIL midop_level got %0d want 3", level); end
        vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL midop_busy got %b want 1", tx_busy); end
        rst = 1'b0;
        #1;
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL async_level got %0d want 0", level); end
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL async_tx_start got %b want 0", tx_start); end
        snap = sent_n;
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        vectors++; if (sent_n !== snap) begin miscompares++; $display("FAIL post_reset_pulses got %0d want 0", sent_n - snap); end
    endtask

    task automatic test_single;
        int base;
        do_reset;
        base = sent_n;
        // store to another address is ignored
        cpu_we = 1'b1; cpu_addr = 32'h4; cpu_wdata = 8'hFF;
        @(negedge clk);
        idle_bus;
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL other_addr_level got %0d want 0", level); end
        repeat (3) @(negedge clk);
        vectors++; if (sent_n !== base) begin miscompares++; $display("FAIL other_addr_pulse got %0d want 0", sent_n - base); end
        drive_store(8'hA5);
        @(negedge clk);
        idle_bus;
        vectors++; if (level !== 4'd1) begin miscompares++; $display("FAIL single_level1 got %0d want 1", level); end
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL single_start_e0 got %b want 0", tx_start); end
        @(negedge clk);
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL single_start_e1 got %b want 0", tx_start); end
        @(negedge clk);
        vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL single_start_e2 got %b want 1", tx_start); end
        vectors++; if (tx_data !== 8'hA5) begin miscompares++; $display("FAIL single_data got %h want a5", tx_data); end
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL single_level0 got %0d want 0", level); end
        @(negedge clk);
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL single_start_e3 got %b want 0", tx_start); end
        repeat (9) @(negedge clk);
        vectors++; if (tx_data !== 8'hA5) begin miscompares++; $display("FAIL single_data_hold got %h want a5", tx_data); end
        repeat (20) @(negedge clk);
        vectors++; if (sent_n !== base + 1) begin miscompares++; $display("FAIL single_count got %0d want 1", sent_n - base); end
    endtask

    task automatic test_fill;
        int base;
        do_reset;
        base = sent_n;
        force_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_store(8'(i));
            @(negedge clk);
        end
        drive_store(8'h08);
        #1;
        vectors++; if (level !== 4'd8) begin miscompares++; $display("FAIL fill_level got %0d want 8", level); end
        vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("FAIL fill_stall got %b want 1", cpu_stall); end
        repeat (2) @(negedge clk);
        vectors++; if (cpu_stall !== 1'b1 || level !== 4'd8) begin miscompares++; $display("FAIL fill_hold stall=%b level=%0d want 1/8", cpu_stall, level); end
        force_busy = 1'b0;
        @(negedge clk);
        vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("FAIL fill_stall_load got %b want 1", cpu_stall); end
        @(negedge clk);
        vectors++; if (cpu_stall !== 1'b0 || level !== 4'd7) begin miscompares++; $display("FAIL fill_free stall=%b level=%0d want 0/7", cpu_stall, level); end
        @(negedge clk);
        idle_bus;
        vectors++; if (level !== 4'd8) begin miscompares++; $display("FAIL fill_retry_level got %0d want 8", level); end
        wait_sent(base + 9, 400, "fill_drain");
        for (int i = 0; i < 9; i++) begin
            vectors++; if (sent[base+i] !== 8'(i)) begin miscompares++; $display("FAIL fill_order[%0d] got %h want %h", i, sent[base+i], 8'(i)); end
        end
    endtask

    task automatic test_back_to_back;
        int base;
        do_reset;
        base = sent_n;
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_store(8'h40 + 8'(i));
            @(negedge clk);
        end
        idle_bus;
        vectors++; if (level !== 4'd4) begin miscompares++; $display("FAIL b2b_level_init got %0d want 4", level); end
        force_busy = 1'b0;
        @(negedge clk);
        drive_store(8'h44);
        @(negedge clk);
        idle_bus;
        vectors++; if (level !== 4'd4 || tx_start !== 1'b1 || tx_data !== 8'h40) begin
            miscompares++; $display("FAIL b2b_first level=%0d start=%b data=%h want 4/1/40", level, tx_start, tx_data);
        end
        // each later pop lands 14 edges after the previous one; push on that edge
        for (int it = 0; it < 20; it++) begin
            repeat (13) @(negedge clk);
            drive_store(8'h45 + 8'(it));
            @(negedge clk);
            idle_bus;
            vectors++; if (level !== 4'd4) begin miscompares++; $display("FAIL b2b_level[%0d] got %0d want 4", it, level); end
            vectors++; if (tx_start !== 1'b1 || tx_data !== 8'h41 + 8'(it)) begin
                miscompares++; $display("FAIL b2b_issue[%0d] start=%b data=%h want 1/%h", it, tx_start, tx_data, 8'h41 + 8'(it));
            end
        end
        wait_sent(base + 25, 600, "b2b_drain");
        for (int i = 0; i < 25; i++) begin
            vectors++; if (sent[base+i] !== 8'h40 + 8'(i)) begin miscompares++; $display("FAIL b2b_order[%0d] got %h want %h", i, sent[base+i], 8'h40 + 8'(i)); end
        end
    endtask

    task automatic test_flush;
        int base;
        do_reset;
        base = sent_n;
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_store(8'h70 + 8'(i));
            @(negedge clk);
        end
        idle_bus;
        vectors++; if (level !== 4'd5) begin miscompares++; $display("FAIL flush_level_init got %0d want 5", level); end
        force_busy = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        drive_store(8'hEE);
        @(negedge clk);
        flush = 1'b0;
        idle_bus;
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL flush_level got %0d want 0", level); end
        vectors++; if (tx_start !== 1'b1 || tx_data !== 8'h70) begin
            miscompares++; $display("FAIL flush_popped start=%b data=%h want 1/70", tx_start, tx_data);
        end
        repeat (40) @(negedge clk);
        vectors++; if (sent_n !== base + 1) begin miscompares++; $display("FAIL flush_pulses got %0d want 1", sent_n - base); end
    endtask

    task automatic test_timeout;
        do_reset;
        model_en = 1'b0;
        drive_store(8'hC3);
        @(negedge clk);
        idle_bus;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (tx_start !== 1'b1 || tx_data !== 8'hC3) begin
            miscompares++; $display("FAIL tmo_first start=%b data=%h want 1/c3", tx_start, tx_data);
        end
        drive_store(8'h3C);
        @(negedge clk);
        idle_bus;
        repeat (ACK_TMO - 2) @(negedge clk);
        vectors++; if (ack_err !== 1'b0) begin miscompares++; $display("FAIL tmo_early got %b want 0", ack_err); end
        @(negedge clk);
        vectors++; if (ack_err !== 1'b1) begin miscompares++; $display("FAIL tmo_set got %b want 1", ack_err); end
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL tmo_idle_start got %b want 0", tx_start); end
        @(negedge clk);
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL tmo_load_start got %b want 0", tx_start); end
        @(negedge clk);
        vectors++; if (tx_start !== 1'b1 || tx_data !== 8'h3C) begin
            miscompares++; $display("FAIL tmo_next start=%b data=%h want 1/3c", tx_start, tx_data);
        end
        vectors++; if (ack_err !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky got %b want 1", ack_err); end
        do_reset;
        vectors++; if (ack_err !== 1'b0) begin miscompares++; $display("FAIL tmo_clear got %b want 0", ack_err); end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        flush = 1'b0;
        force_busy = 1'b0;
        model_en = 1'b1;
        vectors = 0;
        miscompares = 0;
        idle_bus;
        @(negedge clk);
        test_reset;
        test_single;
        test_fill;
        test_back_to_back;
        test_flush;
        test_timeout;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
